fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Fetch-stage sequencer. Owns the fetch PC and drives a req/ready handshake to the instruction memory, so multi-cycle memories work as well as zero-wait ones.
- Presents one registered instruction per cycle to the IF/ID boundary.
- Honours stall_f from the hazard unit and redirects (pc_src_e) from execute, and discards stale responses after a redirect.

Parameters:
- DATA_WIDTH, 32, instruction width
- ADDRESS_WIDTH, 32, PC/address width
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset; also the target for pc_src_e=2'b10
- NOP_INSTR, 32'h0000_0013, value of instr whenever instr_valid=0
- MAX_WAIT, 16, consecutive unanswered request cycles before fetch_err sets

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- stall_f  in  1  hold IF/ID outputs
- pc_src_e  in  2  00 sequential, 01 pc_target, 10 RESET_VECTOR, 11 reserved (treated as 00)
- pc_target  in  ADDRESS_WIDTH  branch/jump target from execute
- imem_req  out  1  request valid
- imem_addr  out  ADDRESS_WIDTH  request address, word-aligned
- imem_ready  in  1  request accepted; imem_rdata valid in the same cycle
- imem_rdata  in  DATA_WIDTH  instruction data
- pc  out  ADDRESS_WIDTH  address of instr
- pc_plus4  out  ADDRESS_WIDTH  pc+4
- instr  out  DATA_WIDTH  fetched instruction
- instr_valid  out  1  instr/pc are meaningful
- fetch_err  out  1  sticky memory timeout flag

Behaviour:
- Reset (rst=0, async): state IDLE, fetch_addr=RESET_VECTOR, imem_req=0, pc=RESET_VECTOR, pc_plus4=RESET_VECTOR+4, instr=NOP_INSTR, instr_valid=0, skid empty, drop=0, wait_cnt=0, fetch_err=0.
- States:
  - IDLE: first clock after reset release goes to FETCH. Exactly one bubble.
  - FETCH: imem_req=1, imem_addr=fetch_addr.
  - HOLD: skid full, imem_req=0.
- Handshake:
  - A transfer completes when imem_req and imem_ready are both high at a clock edge.
  - Once asserted, imem_req stays high with a stable imem_addr until the transfer completes. Stall never withdraws a request; only reset does.
  - A new request is issued only when the output slot or skid can accept the data.
- On a completed transfer with no redirect and drop=0:
  - If instr_valid=0 or stall_f=0: capture into the output registers next edge. pc=fetch_addr, instr=imem_rdata, instr_valid=1.
  - Else: capture into the skid and go to HOLD.
  - In both cases fetch_addr advances by 4, modulo 2^ADDRESS_WIDTH, so 0xFFFF_FFFC wraps to 0.
- Back-to-back: with stall_f=0 and imem_ready=1 every cycle, throughput is 1 instr/cycle. Latency from request to instr_valid is 1 cycle.
- Stall with a valid output: outputs hold. After the current request completes into the skid, no further request is issued.
- HOLD with stall_f=0: skid moves to the outputs, then FETCH resumes at fetch_addr.
- Output with stall_f=0 and no new data: instr_valid=0 next edge, instr=NOP_INSTR.
- Redirect (pc_src_e 01/10), which beats stall:
  - Next edge: instr_valid=0, instr=NOP_INSTR, skid cleared, fetch_addr=target.
  - If a request is outstanding and not completing this cycle, set drop=1. The response is discarded on completion, drop clears, and the next request uses the target address.
  - If a transfer completes in the redirect cycle, its data is discarded.
  - A redirect in IDLE or HOLD issues the target request directly next cycle.
  - Target bits [1:0] are forced to 0.
- Timeout:
  - wait_cnt increments each cycle imem_req=1 and imem_ready=0, and clears on completion.
  - When wait_cnt reaches MAX_WAIT, fetch_err=1 (sticky until reset). Fetching continues to wait.
  - wait_cnt saturates.
- pc_plus4 = pc+4, truncated to ADDRESS_WIDTH, registered with pc.
- Reset mid-transfer: imem_req drops asynchronously and all state returns to reset values.

Test Plan:
- Reset release with imem_ready=1 constantly:
  - imem_req rises 1 cycle after release; instr_valid first high 2 cycles after.
  - pc sequence 0,4,8,C; pc_plus4 sequence 4,8,C,10.
- Memory with 3 wait cycles:
  - imem_addr holds at 0x8 for 4 cycles; instr for pc=0x8 appears exactly once.
  - wait_cnt peaks at 3; fetch_err stays 0.
- stall_f=1 for 5 cycles while a request is in flight:
  - Outputs frozen at pc=0x10; response at 0x14 lands in the skid.
  - After release, pc=0x14 the next cycle, then 0x18 requested. No instruction is lost or duplicated.
- pc_src_e=01, pc_target=0x100 during an outstanding request at 0x20, memory answering 2 cycles later:
  - The 0x20 data is discarded and instr_valid=0.
  - Next request at 0x100; the next valid pc is 0x100.
- Redirect with stall_f=1 in the same cycle, pc_src_e=10: flush wins, instr_valid=0, next fetch at RESET_VECTOR. Separately, fetch_addr=0xFFFF_FFFC with a sequential advance: next request is 0x0.
- imem_ready held 0 for 20 cycles: fetch_err rises after 16 and stays high after ready returns; only rst=0 clears it.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, runs the imem req/ready
// handshake and presents one registered instruction per cycle to IF/ID.
module fetch_ctrl #(
   parameter int                       DATA_WIDTH    = 32,
   parameter int                       ADDRESS_WIDTH = 32,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0,
   parameter logic [DATA_WIDTH-1:0]    NOP_INSTR     = 32'h0000_0013,
   parameter int                       MAX_WAIT      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall_f,
   input  logic [1:0]               pc_src_e,
   input  logic [ADDRESS_WIDTH-1:0] pc_target,
   output logic                     imem_req,
   output logic [ADDRESS_WIDTH-1:0] imem_addr,
   input  logic                     imem_ready,
   input  logic [DATA_WIDTH-1:0]    imem_rdata,
   output logic [ADDRESS_WIDTH-1:0] pc,
   output logic [ADDRESS_WIDTH-1:0] pc_plus4,
   output logic [DATA_WIDTH-1:0]    instr,
   output logic                     instr_valid,
   output logic                     fetch_err
);

   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;
   localparam logic [ADDRESS_WIDTH-1:0] FOUR = ADDRESS_WIDTH'(4);
   localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);

   logic [1:0]               state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] faddr_q, faddr_d;
   logic [ADDRESS_WIDTH-1:0] tgt_q, tgt_d;
   logic                     drop_q, drop_d;
   logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
   logic [ADDRESS_WIDTH-1:0] pc4_q, pc4_d;
   logic [DATA_WIDTH-1:0]    instr_q, instr_d;
   logic                     valid_q, valid_d;
   logic [DATA_WIDTH-1:0]    skid_q, skid_d;
   logic [ADDRESS_WIDTH-1:0] skid_pc_q, skid_pc_d;
   logic [CW-1:0]            wcnt_q, wcnt_d;
   logic                     err_q, err_d;

   logic                     xfer;
   logic                     redir;
   logic [ADDRESS_WIDTH-1:0] target;

   assign imem_req    = (state_q == FETCH);
   assign imem_addr   = faddr_q;
   assign pc          = pc_q;
   assign pc_plus4    = pc4_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign fetch_err   = err_q;

   assign xfer  = imem_req & imem_ready;
   assign redir = (pc_src_e == 2'b01) | (pc_src_e == 2'b10);
   assign target = pc_src_e[1] ?
                   {RESET_VECTOR[ADDRESS_WIDTH-1:2], 2'b00} :
                   {pc_target[ADDRESS_WIDTH-1:2], 2'b00};

   always_comb begin
      state_d   = state_q;
      faddr_d   = faddr_q;
      tgt_d     = tgt_q;
      drop_d    = drop_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      valid_d   = valid_q;
      skid_d    = skid_q;
      skid_pc_d = skid_pc_q;
      wcnt_d    = wcnt_q;

      if (!stall_f) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end

      if (xfer)
         wcnt_d = '0;
      else if (imem_req && wcnt_q != WMAX)
         wcnt_d = wcnt_q + 1'b1;
      err_d = err_q | (wcnt_d == WMAX);

      if (redir) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
         state_d = FETCH;
         // An in-flight request must finish at its old address first
         if (imem_req && !imem_ready) begin
            drop_d = 1'b1;
            tgt_d  = target;
         end else begin
            faddr_d = target;
            drop_d  = 1'b0;
         end
      end else begin
         case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
               if (xfer && drop_q) begin
                  drop_d  = 1'b0;
                  faddr_d = tgt_q;
               end else if (xfer) begin
                  faddr_d = faddr_q + FOUR;
                  if (!valid_q || !stall_f) begin
                     pc_d    = faddr_q;
                     instr_d = imem_rdata;
                     valid_d = 1'b1;
                  end else begin
                     skid_d    = imem_rdata;
                     skid_pc_d = faddr_q;
                     state_d   = HOLD;
                  end
               end
            end
            HOLD: begin
               if (!stall_f) begin
                  pc_d    = skid_pc_q;
                  instr_d = skid_q;
                  valid_d = 1'b1;
                  state_d = FETCH;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      pc4_d = pc_d + FOUR;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         faddr_q   <= RESET_VECTOR;
         tgt_q     <= RESET_VECTOR;
         drop_q    <= 1'b0;
         pc_q      <= RESET_VECTOR;
         pc4_q     <= RESET_VECTOR + FOUR;
         instr_q   <= NOP_INSTR;
         valid_q   <= 1'b0;
         skid_q    <= '0;
         skid_pc_q <= RESET_VECTOR;
         wcnt_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         faddr_q   <= faddr_d;
         tgt_q     <= tgt_d;
         drop_q    <= drop_d;
         pc_q      <= pc_d;
         pc4_q     <= pc4_d;
         instr_q   <= instr_d;
         valid_q   <= valid_d;
         skid_q    <= skid_d;
         skid_pc_q <= skid_pc_d;
         wcnt_q    <= wcnt_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed phases plus random traffic checked
// against a queue-based transaction model of the fetch stage.
module tb_fetch_ctrl;

   localparam logic [31:0] RV  = 32'h0000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int          MW  = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall_f = 1'b0;
   logic [1:0]  pc_src_e = 2'b00;
   logic [31:0] pc_target = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] pc, pc_plus4, instr;
   logic        instr_valid, fetch_err;

   always #5 clk = ~clk;

   fetch_ctrl dut (
      .clk(clk), .rst(rst), .stall_f(stall_f),
      .pc_src_e(pc_src_e), .pc_target(pc_target),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .pc(pc), .pc_plus4(pc_plus4), .instr(instr),
      .instr_valid(instr_valid), .fetch_err(fetch_err)
   );

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   // model state: fetch stream, output slot, buffered instructions
   bit          m_started;
   logic [31:0] m_addr, m_tgt, m_pc, m_instr;
   bit          m_valid, m_drop, m_err;
   int          m_wait;
   ent_t        skq[$];

   function automatic logic [31:0] mem(logic [31:0] a);
      return a ^ 32'hA5C3_0000;
   endfunction

   function automatic bit m_req();
      return m_started && (skq.size() == 0);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_started = 0; m_addr = RV; m_tgt = RV; m_pc = RV;
      m_instr = NOP; m_valid = 0; m_drop = 0; m_err = 0;
      m_wait = 0; skq.delete();
   endtask

   task automatic m_step();
      bit          req, xfer, redir;
      logic [31:0] tgt;
      ent_t        e;
      req   = m_req();
      xfer  = req && imem_ready;
      redir = (pc_src_e == 2'd1) || (pc_src_e == 2'd2);
      tgt   = (pc_src_e == 2'd2) ? RV : {pc_target[31:2], 2'b00};
      if (xfer) m_wait = 0;
      else if (req && m_wait < MW) m_wait++;
      if (m_wait == MW) m_err = 1;
      if (!m_started) begin
         m_started = 1;
         if (redir) m_addr = tgt;
      end else if (redir) begin
         m_valid = 0; m_instr = NOP; skq.delete();
         if (req && !xfer) begin m_drop = 1; m_tgt = tgt; end
         else begin m_addr = tgt; m_drop = 0; end
      end else if (skq.size() != 0) begin
         if (!stall_f) begin
            e = skq.pop_front();
            m_pc = e.pc; m_instr = e.ins; m_valid = 1;
         end
      end else if (xfer && m_drop) begin
         m_drop = 0; m_addr = m_tgt;
         if (!stall_f) begin m_valid = 0; m_instr = NOP; end
      end else if (xfer) begin
         if (!m_valid || !stall_f) begin
            m_pc = m_addr; m_instr = imem_rdata; m_valid = 1;
         end else begin
            e.pc = m_addr; e.ins = imem_rdata; skq.push_back(e);
         end
         m_addr = m_addr + 32'd4;
      end else if (!stall_f) begin
         m_valid = 0; m_instr = NOP;
      end
   endtask

   task automatic check_all();
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_req()});
      if (m_req()) chk("imem_addr", imem_addr, m_addr);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
      chk("instr", instr, m_instr);
      if (m_valid) begin
         chk("pc", pc, m_pc);
         chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      end
      chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
   endtask

   // drive at negedge, model steps with the edge, check at next negedge
   task automatic cyc(bit rdy, bit stl, logic [1:0] src, logic [31:0] tgt);
      imem_ready = rdy;
      stall_f    = stl;
      pc_src_e   = src;
      pc_target  = tgt;
      imem_rdata = rdy ? mem(m_addr) : $urandom;
      @(posedge clk);
      m_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic rnd_cyc(int rpct, int spct, int dpct);
      logic [1:0]  src;
      logic [31:0] tgt;
      src = 2'd0;
      tgt = $urandom;
      if ($urandom_range(99) < dpct) begin
         src = 2'($urandom_range(3, 1));
         case ($urandom_range(3))
            0: tgt = 32'hFFFF_FFFF;
            1: tgt = 32'h0000_0103;
            default: tgt = $urandom;
         endcase
      end
      cyc($urandom_range(99) < rpct, $urandom_range(99) < spct, src, tgt);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      #1 chk("async_req_drop", {31'b0, imem_req}, 32'd0);
      m_reset();
      repeat (2) @(negedge clk);
      chk("rst_pc", pc, RV);
      chk("rst_pc4", pc_plus4, RV + 32'd4);
      check_all();
      rst = 1'b1;
   endtask

   initial begin
      m_reset();
      repeat (2) @(negedge clk);
      chk("rst_pc", pc, RV);
      chk("rst_pc4", pc_plus4, RV + 32'd4);
      check_all();
      rst = 1'b1;

      cyc(1, 0, 2'd0, '0);
      chk("first_req", {31'b0, imem_req}, 32'd1);
      chk("first_bubble", {31'b0, instr_valid}, 32'd0);
      cyc(1, 0, 2'd0, '0);
      chk("first_valid", {31'b0, instr_valid}, 32'd1);
      chk("first_pc", pc, 32'h0);
      repeat (4) cyc(1, 0, 2'd0, '0);

      for (int i = 0; i < 12; i++) cyc(m_wait == 3, 0, 2'd0, '0);

      repeat (3) cyc(1, 0, 2'd0, '0);
      repeat (5) cyc(1, 1, 2'd0, '0);
      repeat (4) cyc(1, 0, 2'd0, '0);

      cyc(0, 0, 2'd0, '0);
      cyc(0, 0, 2'd1, 32'h0000_0100);
      cyc(0, 0, 2'd0, '0);
      cyc(1, 0, 2'd0, '0);
      chk("redir_discard", {31'b0, instr_valid}, 32'd0);
      chk("redir_addr", imem_addr, 32'h100);
      cyc(1, 0, 2'd0, '0);
      chk("redir_pc", pc, 32'h100);

      cyc(1, 1, 2'd2, 32'h0000_0040);
      chk("flush_wins", {31'b0, instr_valid}, 32'd0);
      chk("rv_addr", imem_addr, RV);
      repeat (3) cyc(1, 0, 2'd0, '0);

      cyc(1, 0, 2'd1, 32'hFFFF_FFFF);
      chk("wrap_tgt", imem_addr, 32'hFFFF_FFFC);
      cyc(1, 0, 2'd0, '0);
      chk("wrap_addr", imem_addr, 32'h0);
      repeat (2) cyc(1, 0, 2'd0, '0);

      repeat (20) cyc(0, 0, 2'd0, '0);
      repeat (5) cyc(1, 0, 2'd0, '0);
      chk("err_sticky", {31'b0, fetch_err}, 32'd1);
      do_reset();
      chk("err_cleared", {31'b0, fetch_err}, 32'd0);

      for (int i = 0; i < 1500; i++) rnd_cyc(70, 30, 5);
      do_reset();
      for (int i = 0; i < 1500; i++) rnd_cyc(90, 50, 3);
      for (int i = 0; i < 300; i++) rnd_cyc(8, 20, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
